// File: rtl/echo_avg.sv
// rtl/echo_avg.sv - echo falling-edge capture, range check and 4-sample moving average
module echo_avg #(
  parameter int               CNT_W   = 16,
  parameter logic [CNT_W-1:0] MIN_CNT = 16'd10,
  parameter logic [CNT_W-1:0] MAX_CNT = 16'd3000,
  parameter int               SETTLE  = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             echo_in,
  input  logic [CNT_W-1:0] count_in,
  output logic [CNT_W-1:0] avg_out,
  output logic             avg_valid,
  output logic             oor,
  output logic [2:0]       fill
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_CHECK,
    ST_ACCUM
  } state_t;

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE - 1);

  state_t             state;
  logic               s1, s2, s3;
  logic               fall;
  logic [3:0]         cnt;
  logic [CNT_W-1:0]   sample;
  logic [CNT_W-1:0]   win [4];
  logic [CNT_W+1:0]   sum;
  logic [CNT_W-1:0]   oldest;
  logic [CNT_W+1:0]   sum_next;

  // echo_in is asynchronous: two synchroniser stages plus one history stage for edge detection
  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= echo_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign fall = s3 & ~s2;

  // running sum update; the evicted sample only counts once the window is full
  always_comb begin
    oldest   = '0;
    if (fill == 3'd4) oldest = win[3];
    sum_next = sum + {2'b00, sample} - {2'b00, oldest};
  end

  // measurement FSM with registered window, sum and output pulses
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      sample    <= '0;
      sum       <= '0;
      fill      <= '0;
      avg_out   <= '0;
      avg_valid <= 1'b0;
      oor       <= 1'b0;
      for (int i = 0; i < 4; i++) win[i] <= '0;
    end else begin
      avg_valid <= 1'b0;
      oor       <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (fall) begin
            cnt   <= SETTLE_LOAD;
            state <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          // falls seen here are dropped, not queued
          if (cnt == 4'd0) begin
            sample <= count_in;
            state  <= ST_CHECK;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ST_CHECK: begin
          if (sample >= MIN_CNT && sample <= MAX_CNT) begin
            state <= ST_ACCUM;
          end else begin
            oor   <= 1'b1;
            state <= ST_IDLE;
          end
        end
        ST_ACCUM: begin
          win[0] <= sample;
          win[1] <= win[0];
          win[2] <= win[1];
          win[3] <= win[2];
          sum    <= sum_next;
          if (fill != 3'd4) fill <= fill + 3'd1;
          // average is only published once four samples are in the window
          if (fill >= 3'd3) begin
            avg_valid <= 1'b1;
            avg_out   <= sum_next[CNT_W+1:2];
          end
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_echo_avg.sv
// tb/tb_echo_avg.sv - directed self-checking bench for echo_avg
module tb_echo_avg;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        echo_in = 1'b0;
  logic [15:0] count_in = '0;

  logic [15:0] avg_out, avg_out_m;
  logic        avg_valid, avg_valid_m;
  logic        oor, oor_m;
  logic [2:0]  fill, fill_m;

  int checks = 0;
  int failures = 0;

  int          v_cnt, v_lat, o_cnt, o_lat;
  logic [15:0] v_avg;

  always #5 clk = ~clk;

  echo_avg dut (
    .clk       (clk),
    .reset     (reset),
    .echo_in   (echo_in),
    .count_in  (count_in),
    .avg_out   (avg_out),
    .avg_valid (avg_valid),
    .oor       (oor),
    .fill      (fill)
  );

  echo_avg #(.MAX_CNT(16'hFFFF)) dut_max (
    .clk       (clk),
    .reset     (reset),
    .echo_in   (echo_in),
    .count_in  (count_in),
    .avg_out   (avg_out_m),
    .avg_valid (avg_valid_m),
    .oor       (oor_m),
    .fill      (fill_m)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic watch(input int ncyc);
    v_cnt = 0; v_lat = -1; o_cnt = 0; o_lat = -1; v_avg = '0;
    for (int i = 1; i <= ncyc; i++) begin
      step();
      if (avg_valid) begin
        v_cnt++;
        if (v_lat < 0) begin
          v_lat = i;
          v_avg = avg_out;
        end
      end
      if (oor) begin
        o_cnt++;
        if (o_lat < 0) o_lat = i;
      end
    end
  endtask

  // echo high for 3 cycles, then low; cycle i of the watch is edge k+i-1 relative to the
  // first edge sampling echo low, sampled #1 later
  task automatic measure(input logic [15:0] c);
    count_in = c;
    echo_in  = 1'b1;
    repeat (3) step();
    echo_in = 1'b0;
    watch(12);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) step();
    reset = 1'b0;
  endtask

  initial begin
    step();
    do_reset();
    check("rst_avg_out", 32'(avg_out), 0);
    check("rst_avg_valid", 32'(avg_valid), 0);
    check("rst_oor", 32'(oor), 0);
    check("rst_fill", 32'(fill), 0);

    // fill phase
    measure(16'd100);
    check("fill1_valid", v_cnt, 0);
    check("fill1_fill", 32'(fill), 1);
    check("fill1_avg", 32'(avg_out), 0);
    measure(16'd200);
    check("fill2_fill", 32'(fill), 2);
    check("fill2_valid", v_cnt, 0);
    measure(16'd300);
    check("fill3_fill", 32'(fill), 3);
    check("fill3_valid", v_cnt, 0);
    check("fill3_avg", 32'(avg_out), 0);
    measure(16'd400);
    check("fill4_valid_cnt", v_cnt, 1);
    check("fill4_latency", v_lat, 9);
    check("fill4_avg", 32'(v_avg), 250);
    check("fill4_fill", 32'(fill), 4);
    check("fill4_oor", o_cnt, 0);

    // sliding window
    measure(16'd800);
    check("slide800_valid", v_cnt, 1);
    check("slide800_avg", 32'(v_avg), 425);
    measure(16'd3000);
    check("slide3000_valid", v_cnt, 1);
    check("slide3000_avg", 32'(v_avg), 1125);

    // range rejection
    measure(16'd5);
    check("low_oor_cnt", o_cnt, 1);
    check("low_oor_lat", o_lat, 8);
    check("low_valid", v_cnt, 0);
    check("low_avg_hold", 32'(avg_out), 1125);
    check("low_fill_hold", 32'(fill), 4);
    measure(16'd3001);
    check("high_oor_cnt", o_cnt, 1);
    check("high_valid", v_cnt, 0);
    check("high_avg_hold", 32'(avg_out), 1125);

    // boundary counts accepted
    measure(16'd10);
    check("min_valid", v_cnt, 1);
    check("min_oor", o_cnt, 0);
    check("min_avg", 32'(v_avg), 1052);
    measure(16'd3000);
    check("max_valid", v_cnt, 1);
    check("max_avg", 32'(v_avg), 1702);

    // second falling edge during settle
    count_in = 16'd1000;
    echo_in  = 1'b1;
    repeat (3) step();
    echo_in = 1'b0;
    step();
    step();
    step();
    echo_in = 1'b1;
    step();
    echo_in = 1'b0;
    watch(20);
    check("glitch_valid_cnt", v_cnt, 1);
    check("glitch_oor", o_cnt, 0);
    check("glitch_avg", 32'(v_avg), 1752);

    // reset while in settle with three samples accepted
    do_reset();
    measure(16'd100);
    measure(16'd200);
    measure(16'd300);
    check("pre_rst_fill", 32'(fill), 3);
    count_in = 16'd500;
    echo_in  = 1'b1;
    repeat (3) step();
    echo_in = 1'b0;
    repeat (4) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("mid_rst_fill", 32'(fill), 0);
    check("mid_rst_avg", 32'(avg_out), 0);
    watch(12);
    check("mid_rst_no_valid", v_cnt, 0);
    check("mid_rst_no_oor", o_cnt, 0);
    measure(16'd100);
    measure(16'd200);
    measure(16'd300);
    check("refill3_valid", v_cnt, 0);
    measure(16'd400);
    check("refill4_valid", v_cnt, 1);
    check("refill4_avg", 32'(v_avg), 250);

    // maximum counts with the range limit opened up
    do_reset();
    for (int n = 0; n < 4; n++) measure(16'hFFFF);
    check("maxval_default_oor", o_cnt, 1);
    check("maxval_fill", 32'(fill_m), 4);
    check("maxval_sum", 32'(dut_max.sum), 32'h3FFFC);
    check("maxval_avg", 32'(avg_out_m), 32'hFFFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/echo_avg.md
# echo_avg

Downstream conditioning stage for the ultrasonic echo measurement path. It watches the sensor echo line, detects when a measurement has completed, and captures the 16-bit width count produced by the echo counter stage. Counts outside the valid range are rejected. Accepted counts feed a 4-sample moving average, which is presented to the theremin pitch logic together with a one-cycle valid strobe.

## Interface
- `CNT_W`, 16, width of the count input and the averaged output.
- `MIN_CNT`, 16'd10, smallest accepted count (inclusive).
- `MAX_CNT`, 16'd3000, largest accepted count (inclusive).
- `SETTLE`, 4, system-clock cycles to wait after the echo falling edge before sampling `count_in`, letting the divided-clock counter settle; legal range 1..15.
- `clk` input 1: system clock, the single clock of the block.
- `reset` input 1: synchronous, active-high.
- `echo_in` input 1: raw sensor echo line, asynchronous to `clk`.
- `count_in` input CNT_W: echo width count from the echo counter stage.
- `avg_out` output CNT_W: moving average of the last 4 accepted counts.
- `avg_valid` output 1: one-cycle pulse when `avg_out` is updated.
- `oor` output 1: one-cycle pulse when a captured count is rejected.
- `fill` output 3: number of accepted samples in the window, saturating at 4.

## Operation
- **Input synchroniser.** `echo_in` passes through a 2-FF synchroniser (`s1` then `s2`), followed by a history flop `s3`.
- **Falling edge.** `fall = s3 & ~s2`.
- **FSM states:** IDLE, SETTLE, CHECK, ACCUM.
  - IDLE: on `fall`, load the settle counter with SETTLE-1 and go to SETTLE.
  - SETTLE: decrement the counter. When it reaches 0, latch `count_in` into `sample` and go to CHECK.
  - CHECK: if `MIN_CNT <= sample <= MAX_CNT`, go to ACCUM. Otherwise pulse `oor`, leave the window untouched, and return to IDLE.
  - ACCUM: shift `sample` into the 4-entry window. Update `sum` to `sum + sample - oldest`, where `oldest` is 0 while `fill < 4`. Increment `fill` (saturating at 4). Return to IDLE.
- **Sum and average.**
  - `sum` is CNT_W+2 bits wide and unsigned; it never overflows.
  - `avg_out = sum >> 2`, truncated.
  - `avg_out` is registered and updates only together with `avg_valid`.
- **Output gating.** `avg_valid` pulses in the cycle after ACCUM, and only when the post-update `fill` equals 4. During the first 3 accepted samples `avg_valid` stays low and `avg_out` stays 0.
- **Edge rules.**
  - A `fall` while in SETTLE, CHECK or ACCUM is ignored; it is not queued.
  - A rising edge on `echo_in` has no effect.
- **Reset** (synchronous, any state):
  - State goes to IDLE.
  - Window entries, `sum`, `sample`, `fill` and `avg_out` go to 0.
  - `avg_valid` and `oor` go to 0.
  - Synchroniser flops go to 0.
  - A measurement in progress is discarded with no output pulse.

## Timing
- Reset values: `avg_out`=0, `avg_valid`=0, `oor`=0, `fill`=0.
- **Edge detection.** Let edge k be the first `clk` edge that samples `echo_in` low after it was high. Then `s2` is low after edge k+1, `fall` is high during the cycle after edge k+1, and the FSM enters SETTLE at edge k+2.
- **Sampling point.** SETTLE lasts exactly SETTLE cycles. `count_in` is sampled at edge k+2+SETTLE, which is also the edge at which the FSM enters CHECK.
- **Output latency.**
  - CHECK lasts 1 cycle; `oor` is high for the cycle after edge k+3+SETTLE.
  - ACCUM lasts 1 cycle.
  - `avg_valid` and the new `avg_out` are high/valid for one cycle after edge k+4+SETTLE.
  - Total from edge k: SETTLE+4 edges to the `avg_valid` register update (8 with the default SETTLE).
- **Throughput.** One measurement per SETTLE+3 cycles minimum. This is far below the sensor rate; no backpressure exists.
- `count_in` is assumed stable from the sampling edge onward. The block never samples it outside SETTLE exit.

## Test plan
- **Fill and average.** Reset, then 4 echoes with `count_in` = 100, 200, 300, 400. `fill` goes 1→4. `avg_valid` pulses only after the 4th echo, with `avg_out`=250. `avg_valid` latency is 8 cycles after echo low is sampled.
- **Sliding window.** After the fill above, an echo with count 800 gives `avg_valid` with `avg_out`=425 (1700>>2). A further echo with count 3000 gives 1125.
- **Range rejection.** With the window full, echoes with count 5, then 3001: `oor` pulses once for each, `avg_valid` stays low, and `avg_out` and `fill` are unchanged. Boundary counts 10 and 3000 are accepted.
- **Glitch during settle.** A second high→low on `echo_in` 2 cycles after the first `fall` produces exactly one capture and at most one `avg_valid`.
- **Reset mid-operation.** Assert `reset` for 1 cycle while in SETTLE with `fill`=3. Expect no `avg_valid` and no `oor`, and `fill`=0 and `avg_out`=0 the cycle after. The next 4 valid echoes are needed before `avg_valid` returns.
- **Maximum values.** 4 echoes with `count_in`=16'hFFFF and `MAX_CNT` overridden to 16'hFFFF: `sum`=0x3FFFC with no overflow, and `avg_out`=16'hFFFF.
